// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data widths, memory op encodings, byte-lane constants
// and op-classification helpers used by both cpu and data_memory.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = XLEN / BYTE_W;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;

  localparam logic [LANES-1:0] BE_BYTE = 4'b0001;
  localparam logic [LANES-1:0] BE_HALF = 4'b0011;
  localparam logic [LANES-1:0] BE_WORD = 4'b1111;

  function automatic logic is_load(input mem_op_t op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic is_half(input mem_op_t op);
    return op inside {MEM_LH, MEM_LHU, MEM_SH};
  endfunction

  function automatic logic is_word(input mem_op_t op);
    return op inside {MEM_LW, MEM_SW};
  endfunction

endpackage

// File: rtl/data_memory_load_align.sv
// Extracts the addressed byte/half/word from a memory word and sign- or
// zero-extends it to 32 bits according to the load op.
module data_memory_load_align
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      byte_off_i,
  input  mem_op_t         op_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] shifted_c;

  always_comb begin
    shifted_c = word_i >> {byte_off_i, 3'b000};
    result_o  = '0;
    case (op_i)
      MEM_LB:  result_o = {{24{shifted_c[7]}}, shifted_c[7:0]};
      MEM_LBU: result_o = {24'h0, shifted_c[7:0]};
      MEM_LH:  result_o = {{16{shifted_c[15]}}, shifted_c[15:0]};
      MEM_LHU: result_o = {16'h0, shifted_c[15:0]};
      MEM_LW:  result_o = shifted_c;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory with 1-cycle registered loads.
// Define DATA_MEM_MISALIGN_CHECK_EN to flag/suppress misaligned accesses;
// otherwise misaligned addresses are silently forced to alignment.
module data_memory
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_SIZE_BYTES = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  mem_op_t         mem_ctrl,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] mem_data_in,
  output logic [XLEN-1:0] mem_data_out,
  output logic            misalign_err
);

  localparam int unsigned WORDS = MEM_SIZE_BYTES / LANES;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [LANES-1:0][BYTE_W-1:0] mem_q [WORDS];

  logic [IDX_W-1:0]             idx_c;
  logic [1:0]                   off_c;
  logic                         misaligned_c;
  logic                         store_c;
  logic [LANES-1:0]             be_c;
  logic [LANES-1:0][BYTE_W-1:0] wdata_c;
  logic [XLEN-1:0]              load_val_c;
  logic [XLEN-1:0]              data_out_d, data_out_q;

  // Upper address bits are dropped so accesses wrap at MEM_SIZE_BYTES.
  assign idx_c = IDX_W'(addr[XLEN-1:2] & 30'(WORDS - 1));

  always_comb begin
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    off_c        = addr[1:0];
    misaligned_c = (is_half(mem_ctrl) && addr[0]) ||
                   (is_word(mem_ctrl) && (addr[1:0] != 2'b00));
`else
    misaligned_c = 1'b0;
    if (is_word(mem_ctrl))      off_c = 2'b00;
    else if (is_half(mem_ctrl)) off_c = {addr[1], 1'b0};
    else                        off_c = addr[1:0];
`endif
  end

  // Byte-lane enables and lane-replicated store data.
  always_comb begin
    be_c    = '0;
    wdata_c = mem_data_in;
    case (mem_ctrl)
      MEM_SB: begin
        be_c    = LANES'(BE_BYTE << off_c);
        wdata_c = {LANES{mem_data_in[7:0]}};
      end
      MEM_SH: begin
        be_c    = LANES'(BE_HALF << off_c);
        wdata_c = {2{mem_data_in[15:0]}};
      end
      MEM_SW:  be_c = BE_WORD;
      default: be_c = '0;
    endcase
    store_c = !reset && wr_en && is_store(mem_ctrl) && !misaligned_c;
  end

  always_ff @(posedge clk) begin
    if (store_c) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (be_c[b]) mem_q[idx_c][b] <= wdata_c[b];
      end
    end
  end

  data_memory_load_align u_load_align (
    .word_i     (mem_q[idx_c]),
    .byte_off_i (off_c),
    .op_i       (mem_ctrl),
    .result_o   (load_val_c)
  );

  always_comb begin
    data_out_d = data_out_q;
    if (is_load(mem_ctrl)) data_out_d = misaligned_c ? '0 : load_val_c;
  end

  always_ff @(posedge clk) begin
    if (reset) data_out_q <= '0;
    else       data_out_q <= data_out_d;
  end

  assign mem_data_out = data_out_q;

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  logic misalign_d, misalign_q;

  // A store with wr_en low is not an access, so it never flags.
  always_comb begin
    misalign_d = misaligned_c &&
                 (is_load(mem_ctrl) || (is_store(mem_ctrl) && wr_en));
  end

  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule
